nios_core_mem_loader: RTL and testbench

Byte-stream-to-memory loader on the write side of the Nios on-chip RAM (3750 x 32-bit, 12-bit word address, single port). It accepts a byte stream over a valid/ready handshake, packs four bytes little-endian into 32-bit words, and writes them sequentially from word 0 through the RAM's Avalon-MM slave signals. It keeps a running 32-bit checksum of the written words and can optionally read the image back to verify it before the Nios core leaves reset.

---
 rtl/nios_core_mem_loader.sv | 187 ++++++++++++++++++
 tb/tb_nios_core_mem_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_core_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : nios_core_mem_loader
// Brief    : Packs a little-endian byte stream into 32-bit words and writes
//            them to the Nios on-chip RAM from word 0, keeping a checksum.
//            Optional readback verify: NIOS_CORE_MEM_LOADER_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nios_core_mem_loader #(
   parameter int DEPTH  = 3750,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] word_count,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [31:0]       checksum,
   output logic [ADDR_W-1:0] mem_address,
   output logic [3:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [31:0]       mem_writedata,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WRITE = 3'd2,
      VREAD = 3'd3,
      VCMP  = 3'd4,
      FIN   = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] DEPTH_W  = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       checksum_q, checksum_d;
   logic              error_q, error_d;
   logic              last_word;

`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
   logic [31:0]       vsum_q, vsum_d;
   logic [31:0]       vsum_next;
   assign vsum_next = vsum_q + mem_readdata;
`else
   logic              rd_unused;
   assign rd_unused = ^mem_readdata;
`endif

   assign last_word = (addr_q == (count_q - ADDR_ONE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         byte_idx_q <= '0;
         word_q     <= '0;
         checksum_q <= '0;
         error_q    <= 1'b0;
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
         vsum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         checksum_q <= checksum_d;
         error_q    <= error_d;
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
         vsum_q     <= vsum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      checksum_d = checksum_q;
      error_d    = error_q;
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
      vsum_d     = vsum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               error_d = 1'b0;
               count_d = word_count;
               if (word_count == '0) begin
                  state_d = FIN;
               end else if (word_count > DEPTH_W) begin
                  error_d = 1'b1;
                  state_d = FIN;
               end else begin
                  addr_d     = '0;
                  checksum_d = '0;
                  byte_idx_d = '0;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            if (in_valid) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            checksum_d = checksum_q + word_q;
            if (last_word) begin
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
               addr_d  = '0;
               vsum_d  = '0;
               state_d = VREAD;
`else
               state_d = FIN;
`endif
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = FILL;
            end
         end
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
         VREAD: begin
            state_d = VCMP;
         end
         VCMP: begin
            vsum_d = vsum_next;
            if (last_word) begin
               // Flag the mismatch on entry to FIN so error is valid alongside done.
               error_d = error_q | (vsum_next != checksum_q);
               state_d = FIN;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = VREAD;
            end
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready       = (state_q == FILL);
   assign busy           = (state_q == FILL) || (state_q == WRITE) ||
                           (state_q == VREAD) || (state_q == VCMP);
   assign done           = (state_q == FIN);
   assign error          = error_q;
   assign checksum       = checksum_q;
   assign mem_address    = addr_q;
   assign mem_byteenable = 4'hF;
   assign mem_write      = (state_q == WRITE);
   assign mem_writedata  = word_q;
   assign mem_clken      = 1'b1;
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
   assign mem_chipselect = (state_q == WRITE) || (state_q == VREAD);
`else
   assign mem_chipselect = (state_q == WRITE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_nios_core_mem_loader.sv
`default_nettype none
// Testbench for nios_core_mem_loader: directed loads against a behavioural RAM model.
module tb_nios_core_mem_loader;

   localparam int DEPTH  = 3750;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset, start, in_valid;
   logic [ADDR_W-1:0] word_count;
   logic [7:0]        in_data;
   logic              in_ready, busy, done, error;
   logic [31:0]       checksum, mem_writedata, mem_readdata;
   logic [ADDR_W-1:0] mem_address;
   logic [3:0]        mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nios_core_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .busy(busy), .done(done), .error(error), .checksum(checksum),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // RAM model with per-address write counters and optional corruption of word 5.
   logic [31:0] ram [DEPTH];
   int          wr_cnt [DEPTH];
   int          wr_total, last_wr, done_cnt, cs_cnt;
   bit          clr = 1'b0;
   bit          corrupt_en = 1'b0;

   always @(posedge clk) begin
      if (clr) begin
         for (int a = 0; a < DEPTH; a++) wr_cnt[a] <= 0;
         wr_total <= 0;
         last_wr  <= -1;
      end else if (mem_chipselect && mem_write) begin
         wr_total <= wr_total + 1;
         last_wr  <= int'(mem_address);
         if (int'(mem_address) < DEPTH) begin
            ram[mem_address]    <= (corrupt_en && mem_address == 12'd5) ? ~mem_writedata : mem_writedata;
            wr_cnt[mem_address] <= wr_cnt[mem_address] + 1;
         end
      end
      if (mem_chipselect && !mem_write && int'(mem_address) < DEPTH)
         mem_readdata <= ram[mem_address];
   end

   always @(negedge clk) begin
      if (clr) begin
         done_cnt <= 0;
         cs_cnt   <= 0;
      end else begin
         if (done) done_cnt <= done_cnt + 1;
         if (mem_chipselect) cs_cnt <= cs_cnt + 1;
      end
   end

   function automatic logic [7:0] byte_val(input int mode, input int i);
      int v;
      v = (mode == 0) ? (i + 1) : (i * 13 + (i >> 8));
      return 8'(v);
   endfunction

   function automatic logic [31:0] exp_word(input int mode, input int w);
      return {byte_val(mode, 4*w+3), byte_val(mode, 4*w+2), byte_val(mode, 4*w+1), byte_val(mode, 4*w)};
   endfunction

   task automatic clear_counts;
      @(negedge clk); clr = 1'b1;
      @(negedge clk); @(negedge clk); clr = 1'b0;
   endtask

   task automatic do_start(input int n);
      @(negedge clk); start = 1'b1; word_count = ADDR_W'(n);
      @(negedge clk); start = 1'b0;
   endtask

   task automatic feed(input int mode, input int nbytes, input bit gaps, output bit ok);
      int i = 0;
      int guard = 0;
      while (i < nbytes && guard < 60000) begin
         @(negedge clk);
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = byte_val(mode, i);
            if (in_ready) i++;
         end
         guard++;
      end
      @(negedge clk); in_valid = 1'b0;
      ok = (i == nbytes);
   endtask

   task automatic wait_done(input int bound, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < bound; c++) begin
         if (done) begin seen = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_cmp += 11;
      if (in_ready !== 1'b0)       begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      if (busy !== 1'b0)           begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
      if (done !== 1'b0)           begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
      if (error !== 1'b0)          begin n_fail++; $display("FAIL rst_error got %b want 0", error); end
      if (checksum !== 32'h0)      begin n_fail++; $display("FAIL rst_checksum got %h want 0", checksum); end
      if (mem_address !== 12'h0)   begin n_fail++; $display("FAIL rst_addr got %h want 0", mem_address); end
      if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b want 0", mem_chipselect); end
      if (mem_write !== 1'b0)      begin n_fail++; $display("FAIL rst_write got %b want 0", mem_write); end
      if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", mem_writedata); end
      if (mem_byteenable !== 4'hF) begin n_fail++; $display("FAIL rst_be got %h want F", mem_byteenable); end
      if (mem_clken !== 1'b1)      begin n_fail++; $display("FAIL rst_clken got %b want 1", mem_clken); end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      bit ok, seen;
      clear_counts();
      do_start(2);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
      feed(0, 8, 1'b0, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_feed got stalled want 8 bytes"); end
      wait_done(40, seen);
      n_cmp += 4;
      if (!seen)                     begin n_fail++; $display("FAIL basic_done got none want pulse"); end
      if (checksum !== 32'h0C0A0806) begin n_fail++; $display("FAIL basic_checksum got %h want 0C0A0806", checksum); end
      if (error !== 1'b0)            begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
      if (busy !== 1'b0)             begin n_fail++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
      repeat (3) @(negedge clk);
      n_cmp += 5;
      if (ram[0] !== 32'h04030201) begin n_fail++; $display("FAIL basic_word0 got %h want 04030201", ram[0]); end
      if (ram[1] !== 32'h08070605) begin n_fail++; $display("FAIL basic_word1 got %h want 08070605", ram[1]); end
      if (wr_total != 2)           begin n_fail++; $display("FAIL basic_writes got %0d want 2", wr_total); end
      if (done_cnt != 1)           begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
      if (last_wr != 1)            begin n_fail++; $display("FAIL basic_last_addr got %0d want 1", last_wr); end
   endtask

   task automatic test_zero;
      bit seen;
      clear_counts();
      do_start(0);
      wait_done(3, seen);
      n_cmp += 2;
      if (!seen)          begin n_fail++; $display("FAIL zero_done got none want pulse"); end
      if (error !== 1'b0) begin n_fail++; $display("FAIL zero_error got %b want 0", error); end
      repeat (3) @(negedge clk);
      n_cmp += 2;
      if (cs_cnt != 0)   begin n_fail++; $display("FAIL zero_cs got %0d want 0", cs_cnt); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
   endtask

   task automatic test_oversize;
      bit ok, seen;
      clear_counts();
      do_start(3751);
      wait_done(3, seen);
      n_cmp += 2;
      if (!seen)          begin n_fail++; $display("FAIL over_done got none want pulse"); end
      if (error !== 1'b1) begin n_fail++; $display("FAIL over_error got %b want 1", error); end
      repeat (3) @(negedge clk);
      n_cmp += 2;
      if (cs_cnt != 0)    begin n_fail++; $display("FAIL over_cs got %0d want 0", cs_cnt); end
      if (error !== 1'b1) begin n_fail++; $display("FAIL over_sticky got %b want 1", error); end
      do_start(1);
      n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL over_clear got %b want 0", error); end
      feed(0, 4, 1'b0, ok);
      wait_done(40, seen);
      n_cmp += 2;
      if (!seen)                     begin n_fail++; $display("FAIL over_reload_done got none want pulse"); end
      if (checksum !== 32'h04030201) begin n_fail++; $display("FAIL over_reload_sum got %h want 04030201", checksum); end
   endtask

   task automatic test_backpressure;
      bit ok, seen;
      int bad = 0;
      logic [31:0] sum = 32'h0;
      clear_counts();
      do_start(DEPTH);
      feed(1, 4*DEPTH, 1'b1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_feed got stalled want all bytes"); end
      wait_done(10000, seen);
      n_cmp += 2;
      if (!seen)          begin n_fail++; $display("FAIL bp_done got none want pulse"); end
      if (error !== 1'b0) begin n_fail++; $display("FAIL bp_error got %b want 0", error); end
      for (int w = 0; w < DEPTH; w++) begin
         sum = sum + exp_word(1, w);
         if (wr_cnt[w] != 1 || ram[w] !== exp_word(1, w)) bad++;
      end
      n_cmp += 4;
      if (checksum !== sum) begin n_fail++; $display("FAIL bp_checksum got %h want %h", checksum, sum); end
      if (bad != 0)         begin n_fail++; $display("FAIL bp_words got %0d bad want 0", bad); end
      if (last_wr != DEPTH-1) begin n_fail++; $display("FAIL bp_last_addr got %0d want %0d", last_wr, DEPTH-1); end
      if (wr_total != DEPTH)  begin n_fail++; $display("FAIL bp_writes got %0d want %0d", wr_total, DEPTH); end
   endtask

`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
   task automatic test_verify;
      bit ok, seen;
      clear_counts();
      corrupt_en = 1'b1;
      do_start(8);
      feed(1, 32, 1'b0, ok);
      wait_done(100, seen);
      n_cmp += 2;
      if (!seen)          begin n_fail++; $display("FAIL verify_bad_done got none want pulse"); end
      if (error !== 1'b1) begin n_fail++; $display("FAIL verify_bad_error got %b want 1", error); end
      corrupt_en = 1'b0;
      do_start(8);
      feed(1, 32, 1'b0, ok);
      wait_done(100, seen);
      n_cmp += 2;
      if (!seen)          begin n_fail++; $display("FAIL verify_ok_done got none want pulse"); end
      if (error !== 1'b0) begin n_fail++; $display("FAIL verify_ok_error got %b want 0", error); end
   endtask
`endif

   task automatic test_midload_reset;
      bit ok;
      clear_counts();
      do_start(4);
      feed(0, 6, 1'b0, ok);
      n_cmp += 2;
      if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL mid_pre_ready got %b want 1", in_ready); end
      if (mem_address !== 12'd1) begin n_fail++; $display("FAIL mid_pre_addr got %0d want 1", mem_address); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp += 9;
      if (in_ready !== 1'b0)       begin n_fail++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
      if (busy !== 1'b0)           begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
      if (done !== 1'b0)           begin n_fail++; $display("FAIL mid_done got %b want 0", done); end
      if (error !== 1'b0)          begin n_fail++; $display("FAIL mid_error got %b want 0", error); end
      if (checksum !== 32'h0)      begin n_fail++; $display("FAIL mid_checksum got %h want 0", checksum); end
      if (mem_address !== 12'h0)   begin n_fail++; $display("FAIL mid_addr got %h want 0", mem_address); end
      if (mem_chipselect !== 1'b0) begin n_fail++; $display("FAIL mid_cs got %b want 0", mem_chipselect); end
      if (mem_write !== 1'b0)      begin n_fail++; $display("FAIL mid_write got %b want 0", mem_write); end
      if (mem_writedata !== 32'h0) begin n_fail++; $display("FAIL mid_wdata got %h want 0", mem_writedata); end
      reset = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hAA;
      repeat (12) @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp += 3;
      if (wr_cnt[1] != 0)          begin n_fail++; $display("FAIL mid_word1 got %0d writes want 0", wr_cnt[1]); end
      if (wr_total != 1)           begin n_fail++; $display("FAIL mid_writes got %0d want 1", wr_total); end
      if (ram[0] !== 32'h04030201) begin n_fail++; $display("FAIL mid_word0 got %h want 04030201", ram[0]); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; word_count = '0;
      in_data = 8'h0; in_valid = 1'b0;
      test_reset();
      test_basic();
      test_zero();
      test_oversize();
      test_backpressure();
`ifdef NIOS_CORE_MEM_LOADER_VERIFY_EN
      test_verify();
`endif
      test_midload_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
